eeprom_access_sched: RTL and testbench

//  Scheduler sharing the single I2C EEPROM master (eeprom_wr) between two requesters:
//  a host port (random read/write) and the AD sample logger (sequential writes to a ring region).

---
 rtl/eeprom_access_sched_pkg.sv | 31 +++
 rtl/eeprom_access_sched_arb_rr2.sv | 29 ++
 rtl/eeprom_access_sched.sv | 164 ++++++++++++++++
 tb/tb_eeprom_access_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_access_sched_pkg.sv
// Shared types and constants for the EEPROM access scheduler: FSM states,
// requester ids and the latched master command.
package eeprom_access_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Requester ids double as bit positions in the arbiter request/grant vectors
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_SMP  = 1'b1;

  localparam logic [7:0] DEV_ADDR_DEF = 8'hA0;

  typedef struct packed {
    logic       wr;
    logic [7:0] cs;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  function automatic logic [7:0] ring_next(input logic [7:0] ptr,
                                           input logic [7:0] last,
                                           input logic [7:0] base);
    return (ptr == last) ? base : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/eeprom_access_sched_arb_rr2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the requester that was not granted last.
module arb_rr2
  import eeprom_access_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = 2'b00;
      gnt[~last_grant] = 1'b1;
    end
  end

  // Reset state favours the host on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant <= REQ_SMP;
    else if (update && (|gnt)) last_grant <= gnt[REQ_SMP];
  end

endmodule

// File: rtl/eeprom_access_sched.sv
// Shares the single I2C EEPROM master between the host port and the sample
// logger; one command in flight at a time, with a completion timeout.
module eeprom_access_sched
  import eeprom_access_sched_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter logic [7:0] LOG_BASE    = 8'h00,
  parameter int         LOG_DEPTH   = 128,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_req,
  input  logic       host_wr,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_gnt,
  output logic       host_done,
  output logic       host_err,
  output logic [7:0] host_rdata,
  input  logic       smp_valid,
  input  logic [7:0] smp_data,
  output logic       smp_ready,
  output logic       smp_ovf,
  output logic [7:0] log_ptr,
  output logic       log_wrapped,
  output logic       m_start,
  output logic       m_wr,
  output logic [7:0] m_cs_addr,
  output logic [7:0] m_rw_addr,
  output logic [7:0] m_wdata,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_ack_err,
  input  logic [7:0] m_rdata
);

  localparam int         CW       = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] LOG_LAST = LOG_BASE + 8'(LOG_DEPTH - 1);

  state_e        state, state_nx;
  cmd_t          cmd;
  logic          cur_smp;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_r;
  logic          buf_full;
  logic [7:0]    buf_data;
  logic [1:0]    arb_req, arb_gnt;
  logic          grant_now;

  assign arb_req   = {buf_full, host_req};
  assign grant_now = (state == ST_IDLE) && (|arb_req);
  assign tmo_hit   = (tmo_cnt == TO_LAST);

  arb_rr2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (arb_req),
    .update (grant_now),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    m_start  = 1'b0;
    case (state)
      ST_IDLE:  if (grant_now) state_nx = ST_ISSUE;
      ST_ISSUE: if (!m_busy) begin
        m_start  = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT:  if (m_done || tmo_hit) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Command registers are frozen at grant; later host input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= '0;
      cur_smp  <= 1'b0;
      host_gnt <= 1'b0;
    end else if (grant_now) begin
      cur_smp  <= arb_gnt[REQ_SMP];
      host_gnt <= arb_gnt[REQ_HOST];
      cmd.cs   <= DEV_ADDR;
      if (arb_gnt[REQ_SMP]) begin
        cmd.wr    <= 1'b1;
        cmd.addr  <= log_ptr;
        cmd.wdata <= buf_data;
      end else begin
        cmd.wr    <= host_wr;
        cmd.addr  <= host_addr;
        cmd.wdata <= host_wdata;
      end
    end else if (state == ST_DONE) begin
      host_gnt <= 1'b0;
    end
  end

  // The strobe cycle counts as elapsed, so DONE lands TIMEOUT_CYC cycles after m_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      err_r      <= 1'b0;
      host_rdata <= 8'h00;
    end else begin
      if (m_start)                tmo_cnt <= CW'(1);
      else if (state == ST_WAIT)  tmo_cnt <= tmo_cnt + 1'b1;
      if (state == ST_WAIT) begin
        if (m_done) begin
          err_r <= m_ack_err;
          if (!cur_smp && !cmd.wr && !m_ack_err) host_rdata <= m_rdata;
        end else if (tmo_hit) begin
          err_r <= 1'b1;
        end
      end
    end
  end

  // One-entry sample buffer; freed in DONE, so no same-cycle refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      buf_data <= 8'h00;
      smp_ovf  <= 1'b0;
    end else begin
      if (smp_valid && buf_full) smp_ovf <= 1'b1;
      if (state == ST_DONE && cur_smp) begin
        buf_full <= 1'b0;
      end else if (smp_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= smp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_ptr     <= LOG_BASE;
      log_wrapped <= 1'b0;
    end else if (state == ST_DONE && cur_smp && !err_r) begin
      log_ptr <= ring_next(log_ptr, LOG_LAST, LOG_BASE);
      if (log_ptr == LOG_LAST) log_wrapped <= 1'b1;
    end
  end

  assign host_done = (state == ST_DONE) && !cur_smp;
  assign host_err  = host_done && err_r;
  assign smp_ready = !buf_full;
  assign m_wr      = cmd.wr;
  assign m_cs_addr = cmd.cs;
  assign m_rw_addr = cmd.addr;
  assign m_wdata   = cmd.wdata;

endmodule

// File: tb/tb_eeprom_access_sched.sv
// Scoreboard bench: stimulus pushes expected master commands and host
// completions; a master model and a host monitor pop and compare.
module tb_eeprom_access_sched;

  localparam int         T     = 64;
  localparam int         DEPTH = 4;
  localparam logic [7:0] BASE  = 8'h00;
  localparam logic [7:0] DEV   = 8'hA0;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       host_req = 0, host_wr = 0;
  logic [7:0] host_addr = 0, host_wdata = 0;
  logic       host_gnt, host_done, host_err;
  logic [7:0] host_rdata;
  logic       smp_valid = 0;
  logic [7:0] smp_data = 0;
  logic       smp_ready, smp_ovf, log_wrapped;
  logic [7:0] log_ptr;
  logic       m_start, m_wr;
  logic [7:0] m_cs_addr, m_rw_addr, m_wdata;
  logic       m_busy = 0, m_done = 0, m_ack_err = 0;
  logic [7:0] m_rdata = 0;

  eeprom_access_sched #(.DEV_ADDR(DEV), .LOG_BASE(BASE), .LOG_DEPTH(DEPTH), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_done(host_done), .host_err(host_err), .host_rdata(host_rdata),
    .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready), .smp_ovf(smp_ovf),
    .log_ptr(log_ptr), .log_wrapped(log_wrapped),
    .m_start(m_start), .m_wr(m_wr), .m_cs_addr(m_cs_addr), .m_rw_addr(m_rw_addr), .m_wdata(m_wdata),
    .m_busy(m_busy), .m_done(m_done), .m_ack_err(m_ack_err), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cs, addr, wdata;
    logic       wr;
    int         start_cyc;
    int         delay;
    logic       err;
    logic [7:0] rdata;
    bit         hang;
  } cmd_exp_t;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         rel;
  } host_exp_t;

  cmd_exp_t  cmd_q[$];
  host_exp_t host_q[$];
  cmd_exp_t  rsp;
  host_exp_t hx;
  int n_chk = 0, n_fail = 0, n_starts = 0, last_start = 0;

  // Reference model of the architectural state
  bit         md_last_smp = 1;
  logic [7:0] md_ptr = BASE, md_rdata = 0;
  bit         md_wrapped = 0, md_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++; n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    md_last_smp = 1; md_ptr = BASE; md_rdata = 0; md_wrapped = 0; md_ovf = 0;
  endtask

  task automatic push_host(input logic wr, input logic [7:0] addr, wdata, input int delay,
                           input logic err, input logic [7:0] rdata, input bit hang, input int start_cyc);
    cmd_exp_t c; host_exp_t h; logic e;
    c.cs = DEV; c.wr = wr; c.addr = addr; c.wdata = wdata; c.start_cyc = start_cyc;
    c.delay = delay; c.err = err; c.rdata = rdata; c.hang = hang;
    cmd_q.push_back(c);
    e = hang ? 1'b1 : err;
    if (!wr && !e) md_rdata = rdata;
    h.err = e; h.rdata = md_rdata; h.rel = hang ? T : -1;
    host_q.push_back(h);
    md_last_smp = 0;
  endtask

  task automatic push_smp(input logic [7:0] data, input int delay, input logic err);
    cmd_exp_t c;
    c.cs = DEV; c.wr = 1'b1; c.addr = md_ptr; c.wdata = data; c.start_cyc = -1;
    c.delay = delay; c.err = err; c.rdata = 8'h00; c.hang = 0;
    cmd_q.push_back(c);
    if (!err) begin
      md_ptr = 8'(int'(BASE) + (int'(md_ptr - BASE) + 1) % DEPTH);
      if (md_ptr == BASE) md_wrapped = 1;
    end
    md_last_smp = 1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, host_gnt, 0);   chk({tag, "_done"}, host_done, 0);
    chk({tag, "_err"}, host_err, 0);   chk({tag, "_rdata"}, host_rdata, 0);
    chk({tag, "_ready"}, smp_ready, 1); chk({tag, "_ovf"}, smp_ovf, 0);
    chk({tag, "_ptr"}, log_ptr, BASE); chk({tag, "_wrapped"}, log_wrapped, 0);
    chk({tag, "_mstart"}, m_start, 0); chk({tag, "_mwr"}, m_wr, 0);
    chk({tag, "_mcs"}, m_cs_addr, 0);  chk({tag, "_maddr"}, m_rw_addr, 0);
    chk({tag, "_mwdata"}, m_wdata, 0);
  endtask

  // Master model + command monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_start) begin
        n_starts++; last_start = cyc;
        if (cmd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cmd_unexpected: got addr %0h with no command expected", m_rw_addr);
          rsp.delay = 2; rsp.err = 0; rsp.rdata = 0; rsp.hang = 0;
        end else begin
          rsp = cmd_q.pop_front();
          chk("cmd_cs", m_cs_addr, rsp.cs);   chk("cmd_wr", m_wr, rsp.wr);
          chk("cmd_addr", m_rw_addr, rsp.addr); chk("cmd_wdata", m_wdata, rsp.wdata);
          if (rsp.start_cyc >= 0) chk("start_latency", cyc, rsp.start_cyc);
        end
        @(posedge clk); #1 m_busy = 1;
        if (rsp.hang) begin
          for (int i = 0; i < T + 4 && rst_n; i++) @(posedge clk);
          #1;
        end else begin
          for (int i = 1; i < rsp.delay && rst_n; i++) @(posedge clk);
          #1;
          if (rst_n) begin
            m_done = 1; m_ack_err = rsp.err; m_rdata = rsp.rdata;
            @(posedge clk); #1;
          end
        end
        m_done = 0; m_ack_err = 0; m_busy = 0;
      end
    end
  end

  // Host completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (host_done) begin
        if (host_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL host_done_unexpected: got done err=%0b with none expected", host_err);
        end else begin
          hx = host_q.pop_front();
          chk("host_err", host_err, hx.err);
          chk("host_rdata", host_rdata, hx.rdata);
          if (hx.rel >= 0) chk("timeout_latency", cyc - last_start, hx.rel);
        end
      end
    end
  end

  task automatic host_drive(input logic wr, input logic [7:0] addr, wdata, input int bound);
    int n = 0;
    host_req = 1; host_wr = wr; host_addr = addr; host_wdata = wdata;
    do begin @(negedge clk); n++; end while (!host_done && n < bound);
    if (!host_done) bound_fail("host_done_wait");
    @(posedge clk); #1 host_req = 0;
  endtask

  task automatic smp_wait_ready(input int bound);
    int n = 0;
    do begin @(negedge clk); n++; end while (!smp_ready && n < bound);
    if (!smp_ready) bound_fail("smp_ready_wait");
  endtask

  task automatic smp_offer(input logic [7:0] d);
    smp_wait_ready(300);
    @(posedge clk); #1 smp_valid = 1; smp_data = d;
    @(posedge clk); #1 smp_valid = 0;
  endtask

  // Host and sample pending in the same idle cycle
  task automatic rr_rep(input int r);
    logic [7:0] ha, hd, sd;
    ha = 8'h80 | 8'($urandom_range(0, 127)); hd = 8'($urandom); sd = 8'($urandom);
    if (!md_last_smp) begin
      push_smp(sd, $urandom_range(1, 6), 0);
      push_host(0, ha, 8'h00, $urandom_range(1, 6), 0, hd, 0, -1);
    end else begin
      push_host(0, ha, 8'h00, $urandom_range(1, 6), 0, hd, 0, -1);
      push_smp(sd, $urandom_range(1, 6), 0);
    end
    @(posedge clk); #1 smp_valid = 1; smp_data = sd;
    @(posedge clk); #1 smp_valid = 0;
    fork
      host_drive(0, ha, 8'h00, 300);
      smp_wait_ready(300);
    join
    chk($sformatf("rr%0d_ptr", r), log_ptr, md_ptr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("rst");
    rst_n = 1;
    repeat (2) @(posedge clk);

    // Directed host write with one-cycle grant-to-start latency
    @(posedge clk); #1;
    push_host(1, 8'h10, 8'h5A, 50, 0, 8'h00, 0, cyc + 1);
    host_drive(1, 8'h10, 8'h5A, 200);

    // Directed host read; data must persist after done
    @(posedge clk); #1;
    push_host(0, 8'h20, 8'h00, 7, 0, 8'hC3, 0, cyc + 1);
    host_drive(0, 8'h20, 8'h00, 200);
    repeat (5) @(negedge clk);
    chk("rdata_held", host_rdata, md_rdata);

    // Sequential samples across the ring wrap
    for (int i = 0; i < 5; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      push_smp(d, $urandom_range(1, 8), 0);
      smp_offer(d);
      smp_wait_ready(300);
      chk($sformatf("seq%0d_ptr", i), log_ptr, md_ptr);
      chk($sformatf("seq%0d_wrapped", i), log_wrapped, md_wrapped);
    end

    // Random serialized mix of host and sample commands, with NACKs
    for (int i = 0; i < 14; i++) begin
      logic [7:0] a, d, r; logic w, e;
      a = 8'($urandom); d = 8'($urandom); r = 8'($urandom);
      w = 1'($urandom); e = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
        push_host(w, a, d, $urandom_range(1, 20), e, r, 0, cyc + 1);
        host_drive(w, a, d, 300);
      end else begin
        push_smp(d, $urandom_range(1, 20), e);
        smp_offer(d);
        smp_wait_ready(300);
        chk($sformatf("mix%0d_ptr", i), log_ptr, md_ptr);
      end
    end
    chk("mix_rdata", host_rdata, md_rdata);

    // Overflow: second byte offered while buffer is full gets dropped
    push_smp(8'h11, 10, 0);
    smp_offer(8'h11);
    smp_valid = 1; smp_data = 8'h22;
    @(posedge clk); #1 smp_valid = 0;
    md_ovf = 1;
    chk("ovf_set", smp_ovf, md_ovf);
    smp_wait_ready(300);
    repeat (4) @(negedge clk);
    chk("ovf_sticky", smp_ovf, md_ovf);
    chk("ovf_ptr", log_ptr, md_ptr);

    // Round-robin under contention
    for (int r = 0; r < 4; r++) rr_rep(r);

    // Master never completes: timeout error, then recovery through a stalled issue
    @(posedge clk); #1;
    push_host(0, 8'h44, 8'h00, 0, 0, 8'h00, 1, cyc + 1);
    host_drive(0, 8'h44, 8'h00, T + 40);
    chk("tmo_rdata_kept", host_rdata, md_rdata);
    @(posedge clk); #1;
    push_host(1, 8'h45, 8'h99, 3, 0, 8'h00, 0, -1);
    host_drive(1, 8'h45, 8'h99, 200);

    // Asynchronous reset in the middle of a transaction
    begin
      cmd_exp_t c;
      int n = 0, s0;
      s0 = n_starts;
      c.cs = DEV; c.wr = 1; c.addr = 8'h30; c.wdata = 8'h77; c.start_cyc = -1;
      c.delay = 40; c.err = 0; c.rdata = 0; c.hang = 0;
      cmd_q.push_back(c);
      @(posedge clk); #1 host_req = 1; host_wr = 1; host_addr = 8'h30; host_wdata = 8'h77;
      do begin @(negedge clk); n++; end while (n_starts == s0 && n < 100);
      if (n_starts == s0) bound_fail("reset_test_start");
      repeat (5) @(posedge clk);
      #3 rst_n = 0;
      #1 chk_reset_vals("arst");
      host_req = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
    end

    // After reset the first tie goes to the host again
    rr_rep(4);
    chk("post_rst_wrapped", log_wrapped, md_wrapped);

    repeat (10) @(negedge clk);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("host_q_drained", host_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
